not16_bist: RTL and testbench

Synthesizable built-in self-test sequencer for the 16-bit inverter gate (`Not16`). It drives the gate input and checks the gate output in hardware, so the bench's stimulus and monitor role becomes on-chip logic. It applies a fixed 36-vector pattern set, waits for the gate to settle, and compares each response against the bitwise inversion of the applied vector. It reports error count, first failing vector index, and pass/fail. It sits beside a `Not16` instance in gate-level bring-up builds.

---
 rtl/not16_bist_if.sv | 31 +++
 rtl/not16_bist.sv | 111 +++++++++++
 tb/tb_not16_bist.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/not16_bist_if.sv
// not16_bist_if: signal bundle between the Not16 BIST sequencer and its environment.
//   start          - request a test run
//   dut_in         - vector driven to the gate input
//   dut_out        - gate response
//   busy/done/pass - run status
//   err_count      - mismatching vectors in the current/last run (saturating)
//   first_fail_idx - index of the first failing vector, 63 when none
// The slave modport is the sequencer. The master modport is the surrounding
// logic, which owns both the start request and the gate output.
interface not16_bist_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dut_in;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;
  logic [5:0]       first_fail_idx;

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail_idx
  );

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail_idx
  );
endinterface

// File: rtl/not16_bist.sv
// not16_bist: built-in self-test sequencer for a 16-bit inverter gate.
// It applies 36 fixed vectors, waits SETTLE cycles after each one, and then
// checks the gate response against the bitwise inverse of the vector.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - not16_bist_if slave: start, dut_in, dut_out, busy, done, pass,
//          err_count, first_fail_idx
module not16_bist #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  not16_bist_if.slave  bus
);
  localparam int         CW       = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [5:0] LAST_IDX = 6'd35;
  localparam logic [5:0] NO_FAIL  = 6'd63;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_idx,   w_idx_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_vec,   w_vec_nxt;
  logic [7:0]       r_err,   w_err_nxt;
  logic [5:0]       r_ffi,   w_ffi_nxt;
  logic             w_mismatch;
  logic             w_done;

  // Pattern table: all-zero, all-one, walking one, walking zero, 0x5555, 0xAAAA.
  function automatic logic [WIDTH-1:0] f_vector(input logic [5:0] idx);
    logic [WIDTH-1:0] v;
    if (idx == 6'd0)       v = '0;
    else if (idx == 6'd1)  v = '1;
    else if (idx <= 6'd17) v = WIDTH'(1) << (idx - 6'd2);
    else if (idx <= 6'd33) v = ~(WIDTH'(1) << (idx - 6'd18));
    else if (idx == 6'd34) v = {(WIDTH/2){2'b01}};
    else                   v = {(WIDTH/2){2'b10}};
    return v;
  endfunction

  assign w_mismatch = (bus.dut_out != ~r_vec);
  assign w_done     = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_err_nxt   = r_err;
    w_ffi_nxt   = r_ffi;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_WAIT;
          w_idx_nxt   = '0;
          w_cnt_nxt   = CW'(SETTLE);
          w_vec_nxt   = f_vector(6'd0);
          w_err_nxt   = '0;
          w_ffi_nxt   = NO_FAIL;
        end
      end
      S_WAIT: begin
        // Counter is loaded with SETTLE, so leaving at 1 gives SETTLE wait cycles.
        if (r_cnt <= CW'(1)) w_state_nxt = S_CHECK;
        else                 w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_CHECK: begin
        if (w_mismatch) begin
          if (r_err != 8'hFF)   w_err_nxt = r_err + 8'd1;
          if (r_ffi == NO_FAIL) w_ffi_nxt = r_idx;
        end
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
          w_idx_nxt   = r_idx + 6'd1;
          w_vec_nxt   = f_vector(r_idx + 6'd1);
          w_cnt_nxt   = CW'(SETTLE);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_err   <= '0;
      r_ffi   <= NO_FAIL;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
      r_ffi   <= w_ffi_nxt;
    end
  end

  assign bus.dut_in         = r_vec;
  assign bus.busy           = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign bus.done           = w_done;
  assign bus.pass           = w_done && (r_err == 8'd0);
  assign bus.err_count      = r_err;
  assign bus.first_fail_idx = r_ffi;
endmodule

// File: tb/tb_not16_bist.sv
// tb_not16_bist: scoreboard bench for not16_bist. Each run pushes its expected
// outcome; a monitor pops and compares when done rises. Instance A uses
// SETTLE=1 with a selectable faulty gate model, instance B uses SETTLE=3.
module tb_not16_bist;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  not16_bist_if #(.WIDTH(W)) bus_a ();
  not16_bist_if #(.WIDTH(W)) bus_b ();

  not16_bist #(.WIDTH(W), .SETTLE(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  not16_bist #(.WIDTH(W), .SETTLE(3)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Gate models: 0 good, 1 bit0 stuck-at-0, 2 pass-through, 3 bit15 stuck-at-1
  int unsigned fault = 0;
  always_comb begin
    case (fault)
      1:       bus_a.dut_out = ~bus_a.dut_in & 16'hFFFE;
      2:       bus_a.dut_out = bus_a.dut_in;
      3:       bus_a.dut_out = ~bus_a.dut_in | 16'h8000;
      default: bus_a.dut_out = ~bus_a.dut_in;
    endcase
  end
  assign bus_b.dut_out = ~bus_b.dut_in;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  logic [15:0] tab [36] = '{
    16'h0000, 16'hFFFF,
    16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
    16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000,
    16'hFFFE, 16'hFFFD, 16'hFFFB, 16'hFFF7, 16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F,
    16'hFEFF, 16'hFDFF, 16'hFBFF, 16'hF7FF, 16'hEFFF, 16'hDFFF, 16'hBFFF, 16'h7FFF,
    16'h5555, 16'hAAAA};

  typedef struct {
    int unsigned lat;
    int unsigned err;
    int unsigned ffi;
    int unsigned pass;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int unsigned sa = 0;
  int unsigned sb = 0;

  logic done_a_q = 1'b0;
  always @(negedge clk) begin
    if (bus_a.done && !done_a_q) begin
      if (qa.size() == 0) chk("a_spurious_done", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_latency",   cyc - sa,               e.lat);
        chk("a_err_count", bus_a.err_count,        e.err);
        chk("a_first_idx", bus_a.first_fail_idx,   e.ffi);
        chk("a_pass",      bus_a.pass,             e.pass);
        chk("a_busy_done", bus_a.busy,             0);
      end
    end
    done_a_q <= bus_a.done;
  end

  logic done_b_q = 1'b0;
  always @(negedge clk) begin
    if (bus_b.done && !done_b_q) begin
      if (qb.size() == 0) chk("b_spurious_done", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_latency",   cyc - sb,               e.lat);
        chk("b_err_count", bus_b.err_count,        e.err);
        chk("b_first_idx", bus_b.first_fail_idx,   e.ffi);
        chk("b_pass",      bus_b.pass,             e.pass);
        chk("b_busy_done", bus_b.busy,             0);
      end
    end
    done_b_q <= bus_b.done;
  end

  // One-cycle start pulse on A; on return sa holds the cycle count of the sampling edge.
  task automatic start_a();
    @(negedge clk); #1 bus_a.start = 1'b1;
    @(negedge clk); #1 bus_a.start = 1'b0;
    sa = cyc;
    chk("a_start_busy",  bus_a.busy,   1);
    chk("a_start_done",  bus_a.done,   0);
    chk("a_start_dutin", bus_a.dut_in, 16'h0000);
  endtask

  task automatic run_a(input int unsigned f, input int unsigned err,
                       input int unsigned ffi, input bit pulse_mid);
    exp_t e;
    fault = f;
    e = '{72, err, ffi, (err == 0) ? 1 : 0};
    qa.push_back(e);
    start_a();
    for (int k = 0; k < 200 && qa.size() != 0; k++) begin
      int unsigned el;
      el = cyc - sa;
      if (el < 72 && el % 2 == 0) chk("a_vector", bus_a.dut_in, tab[el / 2]);
      bus_a.start = (pulse_mid && (el == 20 || el == 21));
      @(negedge clk); #1;
    end
    bus_a.start = 1'b0;
    if (qa.size() != 0) begin
      chk("a_done_timeout", 0, 1);
      qa.delete();
    end else begin
      repeat (3) begin @(negedge clk); #1; end
      chk("a_done_held",  bus_a.done,      1);
      chk("a_dutin_held", bus_a.dut_in,    16'hAAAA);
      chk("a_err_held",   bus_a.err_count, err);
    end
  endtask

  task automatic reset_mid_a();
    exp_t e;
    fault = 0;
    e = '{72, 0, 63, 1};
    qa.push_back(e);
    start_a();
    while (cyc - sa < 29) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    qa.delete();
    chk("rstmid_dutin", bus_a.dut_in,         16'h0000);
    chk("rstmid_busy",  bus_a.busy,           0);
    chk("rstmid_done",  bus_a.done,           0);
    chk("rstmid_pass",  bus_a.pass,           0);
    chk("rstmid_err",   bus_a.err_count,      0);
    chk("rstmid_ffi",   bus_a.first_fail_idx, 63);
    repeat (4) begin @(negedge clk); #1; end
    chk("rstmid_idle",  bus_a.busy,           0);
  endtask

  task automatic run_b();
    exp_t e;
    e = '{144, 0, 63, 1};
    qb.push_back(e);
    @(negedge clk); #1 bus_b.start = 1'b1;
    @(negedge clk); #1 bus_b.start = 1'b0;
    sb = cyc;
    chk("b_start_busy", bus_b.busy, 1);
    for (int k = 0; k < 300 && qb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    if (qb.size() != 0) begin
      chk("b_done_timeout", 0, 1);
      qb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dutin", bus_a.dut_in,         16'h0000);
    chk("rst_busy",  bus_a.busy,           0);
    chk("rst_done",  bus_a.done,           0);
    chk("rst_pass",  bus_a.pass,           0);
    chk("rst_err",   bus_a.err_count,      0);
    chk("rst_ffi",   bus_a.first_fail_idx, 63);
    chk("rst_b_ffi", bus_b.first_fail_idx, 63);
    chk("rst_b_done", bus_b.done,          0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_a(0, 0,  63, 1'b0);
    run_a(1, 18, 0,  1'b0);
    run_a(2, 36, 0,  1'b0);
    run_a(3, 18, 1,  1'b0);
    run_a(0, 0,  63, 1'b1);
    reset_mid_a();
    run_a(0, 0,  63, 1'b0);
    run_b();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
